// File: rtl/mul_32b_seq.sv
// Sequential 32x32 -> 64 shift-and-add multiplier with start/busy/done handshake.
// Optional signed operation is enabled by defining MUL_SIGNED_EN.
module mul_32b_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);

`ifdef MUL_SIGNED_EN
  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
`endif

  state_e      r_state;
  logic [31:0] r_acc;
  logic [31:0] r_mq;
  logic [31:0] r_mcand;
  logic [4:0]  r_cnt;
  logic        r_busy;
  logic        r_done;
  logic [63:0] r_product;

  logic [31:0] w_addend;
  logic [31:0] w_sum;
  logic        w_cout;
  logic [31:0] w_a_ld;
  logic [31:0] w_b_ld;

  // One adder pass per RUN cycle; cout becomes the new MSB of the shifted accumulator.
  always_comb begin
    w_addend        = r_mq[0] ? r_mcand : 32'd0;
    {w_cout, w_sum} = {1'b0, r_acc} + {1'b0, w_addend};
  end

`ifdef MUL_SIGNED_EN
  logic        r_neg;
  logic [31:0] w_lo;
  logic        w_lo_c;
  logic [31:0] w_hi;

  // Magnitudes: -0x80000000 wraps to 0x80000000, which reads correctly as unsigned 2^31.
  always_comb begin
    w_a_ld         = a[31] ? (~a + 32'd1) : a;
    w_b_ld         = b[31] ? (~b + 32'd1) : b;
    {w_lo_c, w_lo} = {1'b0, ~r_mq} + 33'd1;
    w_hi           = ~r_acc + {31'd0, w_lo_c};
  end
`else
  always_comb begin
    w_a_ld = a;
    w_b_ld = b;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= StIdle;
      r_acc     <= 32'd0;
      r_mq      <= 32'd0;
      r_mcand   <= 32'd0;
      r_cnt     <= 5'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= 64'd0;
`ifdef MUL_SIGNED_EN
      r_neg     <= 1'b0;
`endif
    end else begin
      case (r_state)
        StIdle: begin
          r_done <= 1'b0;
          if (start) begin
            r_mcand <= w_a_ld;
            r_mq    <= w_b_ld;
            r_acc   <= 32'd0;
            r_cnt   <= 5'd0;
            r_busy  <= 1'b1;
            r_state <= StRun;
`ifdef MUL_SIGNED_EN
            r_neg   <= a[31] ^ b[31];
`endif
          end
        end
        StRun: begin
          {r_acc, r_mq} <= {w_cout, w_sum, r_mq[31:1]};
          r_cnt         <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
`ifdef MUL_SIGNED_EN
            r_state   <= StFix;
`else
            r_state   <= StDone;
            r_done    <= 1'b1;
            r_product <= {w_cout, w_sum, r_mq[31:1]};
`endif
          end
        end
`ifdef MUL_SIGNED_EN
        StFix: begin
          if (r_neg) begin
            {r_acc, r_mq} <= {w_hi, w_lo};
          end
          r_product <= r_neg ? {w_hi, w_lo} : {r_acc, r_mq};
          r_done    <= 1'b1;
          r_state   <= StDone;
        end
`endif
        StDone: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule

// File: tb/tb_mul_32b_seq.sv
// Self-checking bench for mul_32b_seq; expected products are queued at issue and
// popped when done pulses. Define MUL_SIGNED_EN to exercise the signed build.
module tb_mul_32b_seq;

`ifdef MUL_SIGNED_EN
  localparam int LAT = 33;
  localparam int THR = 35;
`else
  localparam int LAT = 32;
  localparam int THR = 34;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;

  logic [63:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  mul_32b_seq dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y);
`ifdef MUL_SIGNED_EN
    logic signed [63:0] sx;
    logic signed [63:0] sy;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    return sx * sy;
`else
    return {32'd0, x} * {32'd0, y};
`endif
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after the accepting edge.
  task automatic issue(input logic [31:0] x, input logic [31:0] y);
    a = x;
    b = y;
    start = 1'b1;
    exp_q.push_back(model(x, y));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output int cyc, output bit seen);
    cyc  = 0;
    seen = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++;
    if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    n_vec++;
    if (product !== 64'd0) begin
      n_err++; $display("FAIL reset_product got %h want 0", product);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_small();
    int cyc; bit seen; logic [63:0] exp;
    issue(32'd3, 32'd5);
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL small_busy got %b want 1", busy); end
    wait_done(LAT + 5, cyc, seen);
    n_vec++;
    if (!seen || cyc != LAT) begin
      n_err++; $display("FAIL small_latency got seen=%0d cyc=%0d want %0d", seen, cyc, LAT);
    end
    exp = exp_q.pop_front();
    n_vec++;
    if (product !== exp || product !== 64'h0000_0000_0000_000F) begin
      n_err++; $display("FAIL small_product got %h want %h", product, exp);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL small_after got done=%b busy=%b want 0 0", done, busy);
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (product !== exp) begin n_err++; $display("FAIL small_hold got %h want %h", product, exp); end
  endtask

  task automatic test_max();
    int cyc; bit seen; logic [63:0] exp;
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(LAT + 5, cyc, seen);
    exp = exp_q.pop_front();
    n_vec++;
    if (!seen || cyc != LAT || product !== exp) begin
      n_err++; $display("FAIL max_product got %h cyc=%0d want %h cyc=%0d", product, cyc, exp, LAT);
    end
`ifndef MUL_SIGNED_EN
    n_vec++;
    if (product !== 64'hFFFF_FFFE_0000_0001) begin
      n_err++; $display("FAIL max_const got %h want fffffffe00000001", product);
    end
`endif
    repeat (2) @(negedge clk);
  endtask

  task automatic test_start_busy();
    int cyc; bit seen; int extra; logic [63:0] exp;
    issue(32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(negedge clk);
    a = 32'h0000_0011;
    b = 32'h0000_0022;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL busy_ignored got busy=%b want 1", busy); end
    wait_done(LAT, cyc, seen);
    exp = exp_q.pop_front();
    n_vec++;
    if (!seen || cyc != LAT - 10 || product !== exp) begin
      n_err++;
      $display("FAIL busy_result got %h cyc=%0d want %h cyc=%0d", product, cyc, exp, LAT - 10);
    end
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    n_vec++;
    if (extra != 0) begin n_err++; $display("FAIL busy_extra_done got %0d want 0", extra); end
  endtask

  task automatic test_reset_mid();
    int cyc; bit seen; logic [63:0] exp;
    issue(32'hDEAD_BEEF, 32'h0000_1234);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0) begin
      n_err++;
      $display("FAIL midreset got busy=%b done=%b prod=%h want 0 0 0", busy, done, product);
    end
    reset = 1'b0;
    void'(exp_q.pop_back());
    @(negedge clk);
    issue(32'd7, 32'd6);
    wait_done(LAT + 5, cyc, seen);
    exp = exp_q.pop_front();
    n_vec++;
    if (!seen || cyc != LAT || product !== exp || product !== 64'd42) begin
      n_err++; $display("FAIL midreset_fresh got %h cyc=%0d want %h cyc=%0d", product, cyc, exp, LAT);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cyc; bit seen; int extra; logic [63:0] exp1; logic [63:0] exp2;
    a = 32'h0001_0000;
    b = 32'h0001_0000;
    start = 1'b1;
    exp_q.push_back(model(a, b));
    exp_q.push_back(model(a, b));
    @(negedge clk);
    wait_done(LAT + 5, cyc, seen);
    exp1 = exp_q.pop_front();
    n_vec++;
    if (!seen || cyc != LAT || product !== exp1 || product !== 64'h0000_0001_0000_0000) begin
      n_err++; $display("FAIL b2b_first got %h cyc=%0d want %h cyc=%0d", product, cyc, exp1, LAT);
    end
    repeat (10) @(negedge clk);
    n_vec++;
    if (busy !== 1'b1 || done !== 1'b0 || product !== exp1) begin
      n_err++;
      $display("FAIL b2b_midrun got busy=%b done=%b prod=%h want 1 0 %h", busy, done, product, exp1);
    end
    wait_done(THR - 10 + 5, cyc, seen);
    start = 1'b0;
    exp2 = exp_q.pop_front();
    n_vec++;
    if (!seen || cyc != THR - 10 || product !== exp2) begin
      n_err++;
      $display("FAIL b2b_second got %h cyc=%0d want %h cyc=%0d", product, cyc, exp2, THR - 10);
    end
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    n_vec++;
    if (extra != 0) begin n_err++; $display("FAIL b2b_extra_done got %0d want 0", extra); end
  endtask

`ifdef MUL_SIGNED_EN
  task automatic test_signed();
    int cyc; bit seen; logic [63:0] exp;
    issue(32'hFFFF_FFFD, 32'd5);
    wait_done(LAT + 5, cyc, seen);
    exp = exp_q.pop_front();
    n_vec++;
    if (!seen || product !== exp || product !== 64'hFFFF_FFFF_FFFF_FFF1) begin
      n_err++; $display("FAIL signed_neg3x5 got %h want %h", product, exp);
    end
    repeat (2) @(negedge clk);
    issue(32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(LAT + 5, cyc, seen);
    exp = exp_q.pop_front();
    n_vec++;
    if (!seen || product !== exp || product !== 64'h0000_0000_8000_0000) begin
      n_err++; $display("FAIL signed_minxneg1 got %h want %h", product, exp);
    end
    repeat (2) @(negedge clk);
  endtask
`endif

  initial begin
    start = 1'b0;
    a     = 32'd0;
    b     = 32'd0;
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_small();
    test_max();
    test_start_busy();
    test_reset_mid();
    test_back_to_back();
`ifdef MUL_SIGNED_EN
    test_signed();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
